// File: rtl/fpu_ui_pkg.sv
// Shared types and constants for the FP ALU demo front-end (state encoding,
// opcodes, timeout result pattern).
package fpu_ui_pkg;

  typedef enum logic [2:0] {
    ST_A_HI = 3'd0,
    ST_A_LO = 3'd1,
    ST_B_HI = 3'd2,
    ST_B_LO = 3'd3,
    ST_OP   = 3'd4,
    ST_WAIT = 3'd5,
    ST_SHOW = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_DEAD;

endpackage

// File: rtl/operand_entry_fsm_key_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on each accepted release-to-press transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry sequencer for the FP ALU demo: collects A, B and opcode via
// NEXT presses, starts the ALU and shows the result. Option: ALU_TIMEOUT_EN.
module operand_entry_fsm
  import fpu_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_next_n,
  input  logic [15:0] sw,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic [31:0] disp_number,
  output logic [2:0]  state_code,
  output logic        err
);

  state_t      state;
  logic [31:0] result;
  logic        press;

  assign state_code = state;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk  (clk),
    .reset(reset),
    .key_n(key_next_n),
    .press(press)
  );

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_A_HI;
      operand_a   <= '0;
      operand_b   <= '0;
      alu_op      <= OP_ADD;
      result      <= '0;
      disp_number <= '0;
      alu_start   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      err         <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      alu_start <= 1'b0;

      // Display echoes the half being edited, from the pre-edge register values.
      case (state)
        ST_A_HI: disp_number <= {sw, operand_a[15:0]};
        ST_A_LO: disp_number <= {operand_a[31:16], sw};
        ST_B_HI: disp_number <= {sw, operand_b[15:0]};
        ST_B_LO: disp_number <= {operand_b[31:16], sw};
        ST_OP:   disp_number <= {30'b0, sw[1:0]};
        ST_SHOW: disp_number <= result;
        default: ;
      endcase

      case (state)
        ST_A_HI: if (press) begin
          operand_a[31:16] <= sw;
          state            <= ST_A_LO;
        end
        ST_A_LO: if (press) begin
          operand_a[15:0] <= sw;
          state           <= ST_B_HI;
        end
        ST_B_HI: if (press) begin
          operand_b[31:16] <= sw;
          state            <= ST_B_LO;
        end
        ST_B_LO: if (press) begin
          operand_b[15:0] <= sw;
          state           <= ST_OP;
        end
        ST_OP: if (press) begin
          alu_op    <= sw[1:0];
          alu_start <= 1'b1;
          state     <= ST_WAIT;
`ifdef ALU_TIMEOUT_EN
          tcnt      <= '0;
`endif
        end
        ST_WAIT: begin
          if (alu_done) begin
            result <= alu_result;
            state  <= ST_SHOW;
          end
`ifdef ALU_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            result <= TIMEOUT_PATTERN;
            err    <= 1'b1;
            state  <= ST_SHOW;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        ST_SHOW: if (press) begin
          state <= ST_A_HI;
`ifdef ALU_TIMEOUT_EN
          err   <= 1'b0;
`endif
        end
        default: state <= ST_A_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with a short debounce window; the
// timeout scenario runs when ALU_TIMEOUT_EN is defined.
module tb_operand_entry_fsm;

  localparam int unsigned DB   = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned HOLD = DB + 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_next_n;
  logic [15:0] sw;
  logic [31:0] alu_result;
  logic        alu_done;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic [31:0] disp_number;
  logic [2:0]  state_code;
  logic        err;

  int n_checks  = 0;
  int n_pass    = 0;
  int start_cnt = 0;

  operand_entry_fsm #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_next_n (key_next_n),
    .sw         (sw),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .disp_number(disp_number),
    .state_code (state_code),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stable release, then hold low long enough for one accepted press.
  task automatic press_key(input int unsigned hold);
    key_next_n = 1'b1;
    tick(HOLD);
    key_next_n = 1'b0;
    tick(hold);
    key_next_n = 1'b1;
  endtask

  task automatic enter_all(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    sw = a[31:16]; press_key(HOLD);
    sw = a[15:0];  press_key(HOLD);
    sw = b[31:16]; press_key(HOLD);
    sw = b[15:0];  press_key(HOLD);
    sw = {14'b0, op}; press_key(HOLD);
  endtask

  initial begin
    key_next_n = 1'b1;
    sw         = '0;
    alu_result = '0;
    alu_done   = 1'b0;
    reset      = 1'b1;
    tick(3);
    check("rst_state", 32'(state_code), 32'd0);
    check("rst_a", operand_a, 32'h0);
    check("rst_b", operand_b, 32'h0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_start", 32'(alu_start), 32'd0);
    check("rst_disp", disp_number, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick(2);

    key_next_n = 1'b0;
    tick(3);
    key_next_n = 1'b1;
    tick(12);
    check("glitch_state", 32'(state_code), 32'd0);

    sw = 16'h3F80;
    press_key(100);
    check("hold_one_adv", 32'(state_code), 32'd1);
    check("a_hi", operand_a, 32'h3F80_0000);
    sw = 16'h1234;
    tick(1);
    check("echo_a_lo", disp_number, 32'h3F80_1234);

    sw = 16'h0000; press_key(HOLD);
    check("a_lo_state", 32'(state_code), 32'd2);
    check("a_full", operand_a, 32'h3F80_0000);
    sw = 16'h4000; press_key(HOLD);
    sw = 16'h0000; press_key(HOLD);
    check("b_lo_state", 32'(state_code), 32'd4);
    check("b_full", operand_b, 32'h4000_0000);
    sw = 16'h0002;
    tick(1);
    check("echo_op", disp_number, 32'h0000_0002);
    sw = 16'h0000; press_key(HOLD);
    check("wait_state", 32'(state_code), 32'd5);
    check("op_add", 32'(alu_op), 32'(fpu_ui_pkg::OP_ADD));
    check("start_once", 32'(start_cnt), 32'd1);
    check("start_low", 32'(alu_start), 32'd0);

    alu_result = 32'h4040_0000;
    alu_done   = 1'b1;
    tick(1);
    alu_done   = 1'b0;
    check("show_state", 32'(state_code), 32'd6);
    tick(1);
    check("show_disp", disp_number, 32'h4040_0000);
    check("show_err", 32'(err), 32'd0);
    press_key(HOLD);
    check("show_to_ahi", 32'(state_code), 32'd0);

    enter_all(32'h1111_2222, 32'h3333_4444, fpu_ui_pkg::OP_DIV);
    check("e2_a", operand_a, 32'h1111_2222);
    check("e2_b", operand_b, 32'h3333_4444);
    check("e2_op", 32'(alu_op), 32'd3);
    check("e2_wait", 32'(state_code), 32'd5);
    check("e2_start", 32'(start_cnt), 32'd2);
`ifndef ALU_TIMEOUT_EN
    press_key(HOLD);
    check("press_in_wait", 32'(state_code), 32'd5);
    check("wait_no_restart", 32'(start_cnt), 32'd2);
`endif

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_state", 32'(state_code), 32'd0);
    check("mid_rst_a", operand_a, 32'h0);
    check("mid_rst_b", operand_b, 32'h0);
    check("mid_rst_op", 32'(alu_op), 32'd0);
    check("mid_rst_disp", disp_number, 32'h0);
    check("mid_rst_err", 32'(err), 32'd0);
    sw         = 16'h0000;
    alu_result = 32'h5555_5555;
    alu_done   = 1'b1;
    tick(5);
    alu_done   = 1'b0;
    check("late_done_state", 32'(state_code), 32'd0);
    check("late_done_disp", disp_number, 32'h0);

`ifdef ALU_TIMEOUT_EN
    enter_all(32'h0000_0001, 32'h0000_0002, fpu_ui_pkg::OP_MUL);
    check("to_wait", 32'(state_code), 32'd5);
    tick(6);
    check("to_still_wait", 32'(state_code), 32'd5);
    tick(1);
    check("to_show", 32'(state_code), 32'd6);
    check("to_err", 32'(err), 32'd1);
    tick(1);
    check("to_disp", disp_number, 32'hDEAD_DEAD);
    press_key(HOLD);
    check("to_ahi", 32'(state_code), 32'd0);
    check("to_err_clr", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_entry_fsm.md
# operand_entry_fsm

Front-end sequencer for the board-level floating-point ALU demo. It debounces the NEXT push-button and collects two 32-bit operands from 16 slide switches, in 16-bit halves, plus a 2-bit opcode. It then issues a one-cycle start to the ALU, waits for done, and latches the result. It is the direct upstream of the seven-segment hex display stage and drives that stage's 32-bit `number` input through `disp_number`.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a synchronised key level must be stable before it is accepted (20 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 1024: ALU done timeout. Used only with `ALU_TIMEOUT_EN`.
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `key_next_n`  in  1  raw NEXT push-button, active-low, asynchronous.
- `sw`  in  16  slide switches: operand half-word; `sw[1:0]` is the opcode in the OP state.
- `alu_result`  in  32  ALU result.
- `alu_done`  in  1  ALU result valid; a pulse or a level.
- `operand_a`  out  32  operand A.
- `operand_b`  out  32  operand B.
- `alu_op`  out  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `alu_start`  out  1  one-cycle start pulse.
- `disp_number`  out  32  value for the hex display, registered.
- `state_code`  out  3  current state encoding, for LEDs.
- `err`  out  1  ALU timeout flag.

## Operation
- **NEXT input path.** `key_next_n` passes through a 2-flop synchroniser into a debouncer.
  - A press is accepted after the synchronised level has been low for `DEBOUNCE_CYCLES` consecutive cycles. This produces a single-cycle `press` pulse.
  - The next press needs a stable high for `DEBOUNCE_CYCLES`, then a new stable low.
  - Holding the key never produces repeats.
- **States** (`state_code`): A_HI=0, A_LO=1, B_HI=2, B_LO=3, OP=4, WAIT=5, SHOW=6.
- **Actions on `press`:**
  - A_HI: `operand_a[31:16]`←`sw`, go to A_LO.
  - A_LO: `operand_a[15:0]`←`sw`, go to B_HI.
  - B_HI: `operand_b[31:16]`←`sw`, go to B_LO.
  - B_LO: `operand_b[15:0]`←`sw`, go to OP.
  - OP: `alu_op`←`sw[1:0]`, go to WAIT.
- **WAIT:**
  - `alu_start`=1 in the first cycle only.
  - On `alu_done`=1: result register←`alu_result`, go to SHOW.
  - `press` is ignored in WAIT.
- **SHOW:** `press` goes to A_HI. Operands and opcode keep their previous values until they are overwritten.
- **`disp_number`** is registered each cycle from the current state:
  - A_HI: {`sw`, `operand_a[15:0]`}.
  - A_LO: {`operand_a[31:16]`, `sw`}.
  - B_HI and B_LO: same as A_HI and A_LO, using `operand_b`.
  - OP: {30'b0, `sw[1:0]`}.
  - WAIT: holds its previous value.
  - SHOW: the latched result.
- **Reset:**
  - State goes to A_HI.
  - `operand_a`, `operand_b`, `alu_op`, result register, `disp_number`, `err` and `alu_start` all go to 0. `state_code` goes to 0.
  - Debounce counters are cleared and the debounced level is set to released.
  - Reset mid-WAIT abandons the operation; a later `alu_done` in A_HI is ignored.

## Timing
- `press` is asserted `DEBOUNCE_CYCLES`+2 cycles after the raw falling edge.
- The state and register update happens on the edge where `press`=1.
- `disp_number` lags `sw` and the state by 1 cycle.
- `alu_start` is high in the cycle after the OP→WAIT transition.
- If `alu_done` is asserted in that same cycle, it is accepted.
- SHOW is entered 1 cycle after `alu_done`. `disp_number` equals `alu_result` 1 cycle after that.
- If `press` and `alu_done` coincide in WAIT, only `alu_done` acts.

## Configuration
- **`ALU_TIMEOUT_EN` defined:**
  - A counter runs in WAIT and is cleared on entry to WAIT.
  - If `TIMEOUT_CYCLES` cycles pass without `alu_done`, go to SHOW, set `err`=1 and latch the result as 32'hDEAD_DEAD.
  - `err` clears when A_HI is entered.
- **Not defined:** WAIT waits indefinitely. `err` is tied to 0 and there is no counter.

## Structure
- Shared package `fpu_ui_pkg` holds:
  - the state enum,
  - opcode constants `OP_ADD`/`OP_SUB`/`OP_MUL`/`OP_DIV`,
  - `TIMEOUT_PATTERN` = 32'hDEAD_DEAD.
- One sub-module, `key_debounce`: synchroniser, stability counter, press pulse, parameterised by `DEBOUNCE_CYCLES`.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4 in simulation.
- **Glitch rejection:** key low for 3 cycles, then high → no `press`, state stays A_HI.
- **Full operand entry:** enter A=3F80_0000, B=4000_0000, op=00 → `operand_a`/`operand_b` match; one `alu_start` pulse; `alu_result`=4040_0000 with done → `disp_number`=4040_0000, `state_code`=6.
- **Live echo:** in A_LO with `operand_a[31:16]`=3F80, `sw`=1234 → `disp_number`=3F80_1234 one cycle later.
- **Hold and WAIT:** key held for 100 cycles → exactly one state advance; `press` in WAIT → ignored.
- **Reset mid-WAIT:** reset during WAIT → all outputs 0 and state A_HI next cycle; a later `alu_done` → no change.
- **Timeout:** `ALU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no done → SHOW after 8 cycles, `disp_number`=DEAD_DEAD, `err`=1; next `press` → A_HI, `err`=0.
